icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised successor to the single-word direct-mapped instruction cache.
- Set-associative, multi-word-line, read-only cache between IF and the memory controller.
- Hits return in the same cycle as the request.
- Misses run a line-refill FSM that fetches LINE_WORDS words sequentially. The FSM supports cancel on branch mispredict and a full invalidate for fence.i.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 1.
- SETS, 16, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, 1 to 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; state clears while rst==0.
- rdy  in  1  global ready; when 0, all sequential state holds.
- pc  in  ADDR_W  fetch address from IF; word aligned, held until ins_flag.
- pc_flag  in  1  fetch request valid.
- ins_ori  out  32  instruction word.
- ins_flag  out  1  ins_ori valid for the current pc.
- jp_wrong  in  1  cancel the current request (mispredict).
- flush  in  1  invalidate all lines.
- pc_mem  out  ADDR_W  word address to the memory controller.
- pc_flag_mem  out  1  memory read request, level-held until ins_mem_flag.
- ins_mem  in  32  word returned by memory.
- ins_mem_flag  in  1  ins_mem valid, 1-cycle pulse.

Behaviour:
- Address split:
  - off = pc[OFF_W+1:2], where OFF_W = log2(LINE_WORDS).
  - idx = next log2(SETS) bits.
  - tag = remaining upper bits.
- Storage, per set and way: valid bit, tag, LINE_WORDS words. Per set: round-robin victim pointer, log2(WAYS) bits.
- Reset (rst==0):
  - All valid bits = 0, victim pointers = 0, state = IDLE, word counter = 0.
  - ins_flag = 0, pc_flag_mem = 0, pc_mem = 0, ins_ori = 0.
- Hit is combinational. In IDLE with pc_flag=1, rdy=1, jp_wrong=0 and a tag match in any valid way of set idx:
  - ins_flag = 1 and ins_ori = that way's word[off], in the same cycle.
  - No memory request is issued.
- FSM states: IDLE, REFILL, DRAIN.
- IDLE → REFILL on pc_flag and miss. Latch line base = pc with offset and byte bits zeroed; latch tag, idx and victim way; counter k = 0.
- REFILL:
  - pc_flag_mem = 1, pc_mem = base + 4*k.
  - On ins_mem_flag: write the word into line buffer slot k, k++.
  - After the word with k == LINE_WORDS-1: write the buffer into the victim way, set valid and tag, advance that set's victim pointer modulo WAYS, go to IDLE.
  - On the next cycle the held pc hits, so miss latency is LINE_WORDS memory transactions plus 1 cycle.
- The line buffer is written to the arrays only on completion. A partial line is never visible.
- jp_wrong:
  - In IDLE: ins_flag forced to 0 that cycle.
  - In REFILL with no ins_mem_flag that cycle: go to DRAIN, keep pc_flag_mem=1 and pc_mem unchanged.
  - In REFILL with ins_mem_flag the same cycle: word discarded, go to IDLE.
  - DRAIN: wait for ins_mem_flag, discard the word, go to IDLE. No line is installed, victim pointer unchanged.
- flush:
  - Clears all valid bits in 1 cycle; ins_flag = 0 that cycle.
  - If flush occurs during REFILL, the in-flight line is still installed on completion. It was fetched after the invalidate point and is legal.
  - flush together with jp_wrong: both actions apply.
- rdy=0: no state change; ins_flag = 0; pc_flag_mem holds its value.
- ins_mem_flag in IDLE (spurious) is ignored.
- pc changing without jp_wrong during REFILL is illegal. IF holds pc until ins_flag.
- LINE_WORDS=1 degenerates to a single-transaction refill. WAYS=1 means the victim pointer is unused (constant 0).

Decomposition:
- Shared package/defines header: state encodings (IDLE/REFILL/DRAIN) and derived widths OFF_W, IDX_W, TAG_W as localparam-style macros next to the existing cache defines.
- Natural sub-module: icache_way. One way's data/tag/valid arrays with combinational read port and synchronous line write, instantiated WAYS times. Hit-select mux and FSM stay in the top.

Test Plan (LINE_WORDS=4, SETS=16, WAYS=2):
- Cold miss, then sequential fetch:
  - pc=0x100 → 4 memory requests at 0x100, 0x104, 0x108, 0x10C.
  - ins_flag one cycle after the 4th ins_mem_flag.
  - pc=0x104, 0x108 then hit in the same cycle with no pc_flag_mem.
- Associativity:
  - Fill 0x100 and 0x500 (both idx 0); both hit afterwards.
  - Fetch 0x900 evicts way 0 (0x100); 0x500 still hits; 0x100 misses.
- Cancel mid-refill:
  - jp_wrong asserted after 2 of 4 words → DRAIN until the 3rd ins_mem_flag, then IDLE.
  - Re-fetching that line misses again (not installed).
- Flush:
  - Hit at 0x100, pulse flush → next request at 0x100 misses and refills.
  - Flush during REFILL → the line is still installed.
- rdy stall:
  - Hold rdy=0 for 5 cycles mid-refill while ins_mem_flag=0 → k and pc_mem unchanged; refill then completes correctly.
- Reset:
  - rst=0 asserted asynchronously mid-refill → outputs 0 immediately.
  - After release, previously cached 0x100 misses.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// rtl/icache_assoc_pkg.sv - shared types and width helpers for the associative instruction cache
package icache_assoc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Storage width for an index that may have only one value (still needs one bit).
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch-side and memory-side handshake bundle of the instruction cache
interface icache_assoc_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              pc_flag;
    logic [31:0]       ins_ori;
    logic              ins_flag;
    logic              jp_wrong;
    logic              flush;
    logic [ADDR_W-1:0] pc_mem;
    logic              pc_flag_mem;
    logic [31:0]       ins_mem;
    logic              ins_mem_flag;

    modport master (
        output pc, pc_flag, jp_wrong, flush, ins_mem, ins_mem_flag,
        input  ins_ori, ins_flag, pc_mem, pc_flag_mem
    );

    modport slave (
        input  pc, pc_flag, jp_wrong, flush, ins_mem, ins_mem_flag,
        output ins_ori, ins_flag, pc_mem, pc_flag_mem
    );
endinterface

// File: rtl/icache_assoc_way.sv
// rtl/icache_assoc_way.sv - one cache way: valid/tag/data arrays, combinational read, whole-line write
module icache_assoc_way
    import icache_assoc_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = 4,
    parameter int OFF_SW     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic [IDX_W-1:0]             rd_idx,
    input  logic [OFF_SW-1:0]            rd_off,
    input  logic [TAG_W-1:0]             rd_tag,
    output logic                         hit,
    output logic [WORD_W-1:0]            rd_word,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_WORDS*WORD_W-1:0] wr_line
);
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS][LINE_WORDS];

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_word = data[rd_idx][rd_off];

    // Clear-then-set ordering lets a line finishing during a flush survive it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (en) begin
            if (clear) valid <= '0;
            if (wr_en) valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en && wr_en) begin
            tags[wr_idx] <= wr_tag;
            for (int j = 0; j < LINE_WORDS; j++) begin
                data[wr_idx][j] <= wr_line[j*WORD_W +: WORD_W];
            end
        end
    end
endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative read-only instruction cache with line-refill FSM
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    icache_assoc_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int OFF_SW = width_min1(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - 2 - IDX_W;
    localparam int WAY_W  = width_min1(WAYS);
    localparam logic [OFF_SW-1:0] OFF_MASK  = OFF_SW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    state_t                  state, state_n;
    logic [OFF_SW-1:0]       k;
    logic [ADDR_W-1:0]       base;
    logic [TAG_W-1:0]        tag_l;
    logic [IDX_W-1:0]        idx_l;
    logic [WAY_W-1:0]        way_l;
    logic [WAY_W-1:0]        victim [SETS];
    logic [WORD_W-1:0]       line_buf [LINE_WORDS];
    logic [LINE_WORDS*WORD_W-1:0] wr_line;

    logic [OFF_SW-1:0]       req_off;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [WAYS-1:0]         way_hit;
    logic [WORD_W-1:0]       way_word [WAYS];
    logic                    any_hit;
    logic [WORD_W-1:0]       hit_word;
    logic                    start_refill, take_word, install;

    assign req_off = OFF_SW'(bus.pc >> 2) & OFF_MASK;
    assign req_idx = IDX_W'(bus.pc >> (OFF_W + 2));
    assign req_tag = TAG_W'(bus.pc >> (OFF_W + 2 + IDX_W));

    // The final word is merged straight from the bus so the line installs on its arrival edge.
    always_comb begin
        wr_line = '0;
        for (int j = 0; j < LINE_WORDS; j++) begin
            wr_line[j*WORD_W +: WORD_W] = (OFF_SW'(j) == k) ? bus.ins_mem : line_buf[j];
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_assoc_way #(
            .LINE_WORDS (LINE_WORDS),
            .SETS       (SETS),
            .TAG_W      (TAG_W),
            .IDX_W      (IDX_W),
            .OFF_SW     (OFF_SW)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .en      (rdy),
            .clear   (bus.flush),
            .rd_idx  (req_idx),
            .rd_off  (req_off),
            .rd_tag  (req_tag),
            .hit     (way_hit[w]),
            .rd_word (way_word[w]),
            .wr_en   (install && (way_l == WAY_W'(w))),
            .wr_idx  (idx_l),
            .wr_tag  (tag_l),
            .wr_line (wr_line)
        );
    end

    always_comb begin
        any_hit  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_word = way_word[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
            base  <= '0;
            tag_l <= '0;
            idx_l <= '0;
            way_l <= '0;
            for (int s = 0; s < SETS; s++) victim[s] <= '0;
        end else if (rdy) begin
            state <= state_n;
            if (start_refill) begin
                base  <= bus.pc & ~LINE_MASK;
                tag_l <= req_tag;
                idx_l <= req_idx;
                way_l <= victim[req_idx];
                k     <= '0;
            end
            if (take_word) k <= install ? '0 : k + OFF_SW'(1);
            if (install && (WAYS > 1)) victim[idx_l] <= victim[idx_l] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && take_word) line_buf[k] <= bus.ins_mem;
    end

    always_comb begin
        state_n      = state;
        start_refill = 1'b0;
        take_word    = 1'b0;
        install      = 1'b0;
        if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (bus.pc_flag && !bus.jp_wrong && !any_hit) begin
                        state_n      = ST_REFILL;
                        start_refill = 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (bus.jp_wrong) begin
                        state_n = bus.ins_mem_flag ? ST_IDLE : ST_DRAIN;
                    end else if (bus.ins_mem_flag) begin
                        take_word = 1'b1;
                        if (k == OFF_MASK) begin
                            install = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.ins_mem_flag) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ins_flag    = (state == ST_IDLE) && rdy && bus.pc_flag && !bus.jp_wrong
                          && !bus.flush && any_hit;
        bus.ins_ori     = bus.ins_flag ? hit_word : '0;
        bus.pc_flag_mem = (state != ST_IDLE);
        bus.pc_mem      = bus.pc_flag_mem ? base + (ADDR_W'(k) << 2) : '0;
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed self-checking bench for icache_assoc (4 words, 16 sets, 2 ways)
module tb_icache_assoc;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   tests = 0;
    int   fails = 0;

    icache_assoc_if #(.ADDR_W(32)) bus ();

    icache_assoc #(
        .ADDR_W     (32),
        .LINE_WORDS (4),
        .SETS       (16),
        .WAYS       (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory content: every word equals its address plus 0x1000_0000.
    task automatic serve_word(input logic [31:0] exp_addr);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (bus.pc_flag_mem !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        tests++;
        if (bus.pc_flag_mem !== 1'b1 || bus.pc_mem !== exp_addr) begin
            fails++;
            $display("FAIL mem_req: pc_flag_mem=%b pc_mem=%h, want 1 / %h", bus.pc_flag_mem, bus.pc_mem, exp_addr);
        end
        bus.ins_mem      = exp_addr + 32'h1000_0000;
        bus.ins_mem_flag = 1'b1;
        @(negedge clk);
        bus.ins_mem_flag = 1'b0;
        bus.ins_mem      = '0;
        #1;
    endtask

    task automatic fetch_miss(input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'hF;
        bus.pc      = addr;
        bus.pc_flag = 1'b1;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b0) begin
            fails++;
            $display("FAIL miss_detect %h: ins_flag=%b, want 0", addr, bus.ins_flag);
        end
        for (int i = 0; i < 4; i++) serve_word(base + 32'(i * 4));
        tests++;
        if (bus.ins_flag !== 1'b1 || bus.ins_ori !== addr + 32'h1000_0000) begin
            fails++;
            $display("FAIL refill_done %h: ins_flag=%b ins_ori=%h, want 1 / %h", addr, bus.ins_flag, bus.ins_ori, addr + 32'h1000_0000);
        end
        @(negedge clk);
        bus.pc_flag = 1'b0;
        #1;
    endtask

    task automatic fetch_hit(input logic [31:0] addr);
        bus.pc      = addr;
        bus.pc_flag = 1'b1;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b1 || bus.ins_ori !== addr + 32'h1000_0000 || bus.pc_flag_mem !== 1'b0) begin
            fails++;
            $display("FAIL hit %h: ins_flag=%b ins_ori=%h pc_flag_mem=%b, want 1 / %h / 0", addr, bus.ins_flag, bus.ins_ori, bus.pc_flag_mem, addr + 32'h1000_0000);
        end
        @(negedge clk);
        bus.pc_flag = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1;
        bus.pc = '0; bus.pc_flag = 1'b0; bus.jp_wrong = 1'b0; bus.flush = 1'b0;
        bus.ins_mem = '0; bus.ins_mem_flag = 1'b0;
        #2 rst = 1'b0;
        bus.pc = 32'h100; bus.pc_flag = 1'b1;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b0) begin fails++; $display("FAIL reset_ins_flag: %b, want 0", bus.ins_flag); end
        tests++;
        if (bus.ins_ori !== 32'h0) begin fails++; $display("FAIL reset_ins_ori: %h, want 0", bus.ins_ori); end
        tests++;
        if (bus.pc_flag_mem !== 1'b0) begin fails++; $display("FAIL reset_pc_flag_mem: %b, want 0", bus.pc_flag_mem); end
        tests++;
        if (bus.pc_mem !== 32'h0) begin fails++; $display("FAIL reset_pc_mem: %h, want 0", bus.pc_mem); end
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.pc_flag = 1'b0;
        #1;
        bus.ins_mem = 32'hDEAD_BEEF; bus.ins_mem_flag = 1'b1;
        @(negedge clk);
        bus.ins_mem_flag = 1'b0;
        #1;
        tests++;
        if (bus.pc_flag_mem !== 1'b0) begin fails++; $display("FAIL spurious_mem_flag: pc_flag_mem=%b, want 0", bus.pc_flag_mem); end
    endtask

    task automatic test_cold_miss();
        fetch_miss(32'h100);
        fetch_hit(32'h104);
        fetch_hit(32'h108);
        bus.pc = 32'h10C; bus.pc_flag = 1'b1; bus.jp_wrong = 1'b1;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b0) begin fails++; $display("FAIL jp_wrong_idle: ins_flag=%b, want 0", bus.ins_flag); end
        bus.jp_wrong = 1'b0;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b1 || bus.ins_ori !== 32'h1000_010C) begin
            fails++;
            $display("FAIL hit_after_jp: ins_flag=%b ins_ori=%h, want 1 / 1000010c", bus.ins_flag, bus.ins_ori);
        end
        @(negedge clk);
        bus.pc_flag = 1'b0;
        #1;
    endtask

    task automatic test_assoc();
        fetch_miss(32'h500);
        fetch_hit(32'h100);
        fetch_hit(32'h50C);
        fetch_miss(32'h900);
        fetch_hit(32'h500);
        fetch_miss(32'h100);
    endtask

    task automatic test_cancel();
        bus.pc = 32'h340; bus.pc_flag = 1'b1;
        #1;
        serve_word(32'h340);
        serve_word(32'h344);
        bus.jp_wrong = 1'b1; bus.pc_flag = 1'b0;
        #1;
        tests++;
        if (bus.pc_flag_mem !== 1'b1) begin fails++; $display("FAIL cancel_req_held: pc_flag_mem=%b, want 1", bus.pc_flag_mem); end
        @(negedge clk);
        bus.jp_wrong = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (bus.pc_flag_mem !== 1'b1 || bus.pc_mem !== 32'h348) begin
            fails++;
            $display("FAIL drain_hold: pc_flag_mem=%b pc_mem=%h, want 1 / 348", bus.pc_flag_mem, bus.pc_mem);
        end
        bus.ins_mem = 32'h1000_0348; bus.ins_mem_flag = 1'b1;
        @(negedge clk);
        bus.ins_mem_flag = 1'b0;
        #1;
        tests++;
        if (bus.pc_flag_mem !== 1'b0) begin fails++; $display("FAIL drain_exit: pc_flag_mem=%b, want 0", bus.pc_flag_mem); end
        fetch_miss(32'h340);
    endtask

    task automatic test_flush();
        fetch_hit(32'h340);
        bus.pc = 32'h340; bus.pc_flag = 1'b1; bus.flush = 1'b1;
        #1;
        tests++;
        if (bus.ins_flag !== 1'b0) begin fails++; $display("FAIL flush_blocks_hit: ins_flag=%b, want 0", bus.ins_flag); end
        @(negedge clk);
        bus.flush = 1'b0; bus.pc_flag = 1'b0;
        #1;
        fetch_miss(32'h340);
        bus.pc = 32'h680; bus.pc_flag = 1'b1;
        #1;
        serve_word(32'h680);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        for (int i = 1; i < 4; i++) serve_word(32'h680 + 32'(i * 4));
        tests++;
        if (bus.ins_flag !== 1'b1 || bus.ins_ori !== 32'h1000_0680) begin
            fails++;
            $display("FAIL flush_during_refill: ins_flag=%b ins_ori=%h, want 1 / 10000680", bus.ins_flag, bus.ins_ori);
        end
        @(negedge clk);
        bus.pc_flag = 1'b0;
        #1;
        fetch_hit(32'h68C);
        fetch_miss(32'h340);
    endtask

    task automatic test_rdy_stall();
        bus.pc = 32'h7A0; bus.pc_flag = 1'b1;
        #1;
        serve_word(32'h7A0);
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.pc_flag_mem !== 1'b1 || bus.pc_mem !== 32'h7A4 || bus.ins_flag !== 1'b0) begin
                fails++;
                $display("FAIL rdy_stall c%0d: pc_flag_mem=%b pc_mem=%h ins_flag=%b, want 1 / 7a4 / 0", c, bus.pc_flag_mem, bus.pc_mem, bus.ins_flag);
            end
        end
        rdy = 1'b1;
        for (int i = 1; i < 4; i++) serve_word(32'h7A0 + 32'(i * 4));
        tests++;
        if (bus.ins_flag !== 1'b1 || bus.ins_ori !== 32'h1000_07A0) begin
            fails++;
            $display("FAIL stall_refill_done: ins_flag=%b ins_ori=%h, want 1 / 100007a0", bus.ins_flag, bus.ins_ori);
        end
        @(negedge clk);
        bus.pc_flag = 1'b0;
        #1;
        fetch_hit(32'h7A8);
    endtask

    task automatic test_async_reset();
        fetch_miss(32'h100);
        fetch_hit(32'h100);
        bus.pc = 32'h2C0; bus.pc_flag = 1'b1;
        #1;
        serve_word(32'h2C0);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (bus.pc_flag_mem !== 1'b0 || bus.pc_mem !== 32'h0 || bus.ins_flag !== 1'b0 || bus.ins_ori !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: pc_flag_mem=%b pc_mem=%h ins_flag=%b ins_ori=%h, want all 0", bus.pc_flag_mem, bus.pc_mem, bus.ins_flag, bus.ins_ori);
        end
        bus.pc_flag = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        fetch_miss(32'h100);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_assoc();
        test_cancel();
        test_flush();
        test_rdy_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
